// File: rtl/wave_lut_pkg.sv
// Shared constants for the wave_lut sample generator: waveform codes, ROM geometry,
// full-scale and unity-amplitude values, and the quarter-sine table generator.
package wave_lut_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  localparam int ROM_DEPTH  = 1024;
  localparam int ROM_AW     = 10;
  localparam int ROM_WIDTH  = 11;
  localparam int FULL_SCALE = 2047;
  localparam int UNITY_AMP  = 256;

  // pi scaled by 2^60
  localparam logic [127:0] QSIN_PI_FX = 128'h3243F6A8885A308D;

  // round(2047 * sin(pi/2 * (i + 0.5) / 1024)) in 2^60 fixed point via Taylor series,
  // evaluated at elaboration so the table is a constant.
  function automatic logic [ROM_WIDTH-1:0] qsin_entry(input int unsigned i);
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] acc;
    x    = (QSIN_PI_FX * 128'(2 * i + 1)) >> 12;
    x2   = (x * x) >> 60;
    term = x;
    acc  = x;
    for (int k = 1; k <= 12; k++) begin
      term = ((term * x2) >> 60) / 128'((2 * k) * (2 * k + 1));
      if ((k % 2) == 1) acc = acc - term;
      else              acc = acc + term;
    end
    return 11'((acc * 128'(FULL_SCALE) + (128'd1 << 59)) >> 60);
  endfunction

endpackage

// File: rtl/wave_lut_qsin_rom.sv
// Quarter-wave sine ROM: 1024 x 11-bit constant table with a registered read port.
module qsin_rom
  import wave_lut_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [ROM_AW-1:0]    i_addr,
  output logic [ROM_WIDTH-1:0] o_data
);

  logic [ROM_WIDTH-1:0] w_rom [ROM_DEPTH];
  logic [ROM_WIDTH-1:0] r_data;

  for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
    localparam logic [ROM_WIDTH-1:0] LP_VAL = qsin_entry(gi);
    assign w_rom[gi] = LP_VAL;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_data <= '0;
    else          r_data <= w_rom[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/wave_lut.sv
// Waveform lookup pipeline: strobe sync, capture, ROM read, waveform shaping, amplitude scale.
// Each stage valid marks that stage's data as a live sample; there is no back-pressure.
module wave_lut
  import wave_lut_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        s_clk,
  input  logic        en,
  input  logic [11:0] addr,
  input  logic [1:0]  wave_sel,
  input  logic [8:0]  amp,
  output logic [11:0] dout,
  output logic        dout_vld
);

  logic r_pl0;
  logic r_pl1;
  logic r_stb_d1;
  logic w_stb;

  assign w_stb = r_pl0 & ~r_pl1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pl0    <= 1'b0;
      r_pl1    <= 1'b0;
      r_stb_d1 <= 1'b0;
    end else begin
      r_pl0    <= s_clk;
      r_pl1    <= r_pl0;
      r_stb_d1 <= w_stb;
    end
  end

  // stage 1: capture upstream inputs one clk after the strobe
  logic        r_s1_vld;
  logic [11:0] r_s1_addr;
  logic [1:0]  r_s1_wave_sel;
  logic [8:0]  r_s1_amp;
  logic        w_s1_take;

  assign w_s1_take = r_stb_d1 & en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_vld      <= 1'b0;
      r_s1_addr     <= '0;
      r_s1_wave_sel <= '0;
      r_s1_amp      <= '0;
    end else begin
      r_s1_vld <= w_s1_take;
      if (w_s1_take) begin
        r_s1_addr     <= addr;
        r_s1_wave_sel <= wave_sel;
        r_s1_amp      <= amp;
      end
    end
  end

  // odd quadrants walk the quarter table backwards; 1023 - idx is ~idx
  logic [ROM_AW-1:0]    w_rom_idx;
  logic [ROM_WIDTH-1:0] w_rom_data;

  assign w_rom_idx = r_s1_addr[10] ? ~r_s1_addr[9:0] : r_s1_addr[9:0];

  qsin_rom u_qsin_rom (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_addr  (w_rom_idx),
    .o_data  (w_rom_data)
  );

  // stage 2: side data aligned with the registered ROM output
  logic        r_s2_vld;
  logic        r_s2_q1;
  logic [11:0] r_s2_addr;
  logic [1:0]  r_s2_wave_sel;
  logic [8:0]  r_s2_amp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_vld      <= 1'b0;
      r_s2_q1       <= 1'b0;
      r_s2_addr     <= '0;
      r_s2_wave_sel <= '0;
      r_s2_amp      <= '0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_q1       <= r_s1_addr[11];
        r_s2_addr     <= r_s1_addr;
        r_s2_wave_sel <= r_s1_wave_sel;
        r_s2_amp      <= r_s1_amp;
      end
    end
  end

  // stage 3: full-scale signed sample
  logic [9:0]  w_tri_t;
  logic [11:0] w_tri_mag;
  logic [11:0] w_rom_pos;
  logic [11:0] w_sample;

  always_comb begin
    w_tri_t   = r_s2_addr[10] ? ~r_s2_addr[9:0] : r_s2_addr[9:0];
    w_tri_mag = {1'b0, w_tri_t, w_tri_t[9]};
    w_rom_pos = {1'b0, w_rom_data};
    w_sample  = '0;
    case (r_s2_wave_sel)
      WAVE_SINE:   w_sample = r_s2_q1 ? (12'd0 - w_rom_pos) : w_rom_pos;
      WAVE_SQUARE: w_sample = r_s2_addr[11] ? (12'd0 - 12'(FULL_SCALE)) : 12'(FULL_SCALE);
      WAVE_TRI:    w_sample = r_s2_addr[11] ? (12'd0 - w_tri_mag) : w_tri_mag;
      WAVE_SAW:    w_sample = {~r_s2_addr[11], r_s2_addr[10:0]};
      default:     w_sample = '0;
    endcase
  end

  logic        r_s3_vld;
  logic [11:0] r_s3_sample;
  logic [8:0]  r_s3_amp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s3_vld    <= 1'b0;
      r_s3_sample <= '0;
      r_s3_amp    <= '0;
    end else begin
      r_s3_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_s3_sample <= w_sample;
        r_s3_amp    <= r_s2_amp;
      end
    end
  end

  // stage 4: clamp gain at unity, multiply, arithmetic shift floors toward -inf
  logic [8:0]         w_amp_eff;
  logic signed [20:0] w_prod;
  logic               w_unused;

  assign w_amp_eff = (r_s3_amp > 9'(UNITY_AMP)) ? 9'(UNITY_AMP) : r_s3_amp;
  assign w_prod    = $signed({{9{r_s3_sample[11]}}, r_s3_sample}) * $signed({12'd0, w_amp_eff});
  assign w_unused  = ^{w_prod[20], w_prod[7:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= r_s3_vld;
      if (r_s3_vld) dout <= w_prod[19:8];
    end
  end

endmodule

// File: tb/tb_wave_lut.sv
// Bench for wave_lut: constant vector table, latency/enable/reset sequences, and random
// samples scored against a real-arithmetic waveform model.
module tb_wave_lut;
  import wave_lut_pkg::*;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_clk;
  logic        en;
  logic [11:0] addr;
  logic [1:0]  wave_sel;
  logic [8:0]  amp;
  logic [11:0] dout;
  logic        dout_vld;

  int          n_tests;
  int          n_fail;
  int          n_pulses;
  int          p0;
  logic [11:0] mon_exp;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  ws;
    logic [8:0]  amp;
    int          exp;
  } vec_t;

  vec_t vecs[18];

  wave_lut dut (
    .clk      (clk),
    .rst      (rst),
    .s_clk    (s_clk),
    .en       (en),
    .addr     (addr),
    .wave_sel (wave_sel),
    .amp      (amp),
    .dout     (dout),
    .dout_vld (dout_vld)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // reference model: waveform defined directly from phase angle / position in the cycle
  function automatic int model(input int a, input int ws, input int am);
    int  s;
    int  t;
    int  ae;
    real v;
    case (ws)
      0: begin
        v = 2047.0 * $sin(2.0 * PI * (real'(a) + 0.5) / 4096.0);
        s = (v < 0.0) ? -$rtoi($floor(-v + 0.5)) : $rtoi($floor(v + 0.5));
      end
      1: s = (a < 2048) ? 2047 : -2047;
      2: begin
        t = a % 1024;
        if (((a / 1024) % 2) == 1) t = 1023 - t;
        s = 2 * t + t / 512;
        if (a >= 2048) s = -s;
      end
      default: s = a - 2048;
    endcase
    ae = (am > 256) ? 256 : am;
    return $rtoi($floor(real'(s * ae) / 256.0));
  endfunction

  // driver: one s_clk pulse, inputs presented one clk after the strobe (after E0)
  task automatic drive_sample(input logic [11:0] a, input logic [1:0] ws, input logic [8:0] am,
                              input logic e, input int exp, input int gap);
    s_clk = 1'b1;
    @(negedge clk);
    s_clk = 1'b0;
    @(negedge clk);
    addr     = a;
    wave_sel = ws;
    amp      = am;
    en       = e;
    if (e) exp_q.push_back(12'(exp));
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check(name, 12'(exp_q.size()), 12'd0);
  endtask

  // scoreboard: every dout_vld pulse consumes one expected sample
  always @(negedge clk) begin
    if (rst === 1'b1 && dout_vld === 1'b1) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        check("vld_unexpected", {11'd0, dout_vld}, 12'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("dout", dout, mon_exp);
      end
    end
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    n_pulses = 0;
    rst      = 1'b0;
    s_clk    = 1'b0;
    en       = 1'b0;
    addr     = '0;
    wave_sel = '0;
    amp      = '0;

    vecs[0]  = '{12'd0,    WAVE_SINE,   9'd256, 2};
    vecs[1]  = '{12'd1024, WAVE_SINE,   9'd256, 2047};
    vecs[2]  = '{12'd3072, WAVE_SINE,   9'd256, -2047};
    vecs[3]  = '{12'd2048, WAVE_SQUARE, 9'd256, -2047};
    vecs[4]  = '{12'd0,    WAVE_SQUARE, 9'd256, 2047};
    vecs[5]  = '{12'd0,    WAVE_SAW,    9'd256, -2048};
    vecs[6]  = '{12'd4095, WAVE_SAW,    9'd256, 2047};
    vecs[7]  = '{12'd0,    WAVE_TRI,    9'd256, 0};
    vecs[8]  = '{12'd1024, WAVE_TRI,    9'd256, 2047};
    vecs[9]  = '{12'd3072, WAVE_TRI,    9'd256, -2047};
    vecs[10] = '{12'd1024, WAVE_SINE,   9'd128, 1023};
    vecs[11] = '{12'd3072, WAVE_SINE,   9'd128, -1024};
    vecs[12] = '{12'd1024, WAVE_SINE,   9'd400, 2047};
    vecs[13] = '{12'd3072, WAVE_SINE,   9'd400, -2047};
    vecs[14] = '{12'd512,  WAVE_TRI,    9'd256, 1025};
    vecs[15] = '{12'd0,    WAVE_SAW,    9'd1,   -8};
    vecs[16] = '{12'd4095, WAVE_SAW,    9'd1,   7};
    vecs[17] = '{12'd2048, WAVE_SINE,   9'd0,   0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 12'd0);
    check("rst_vld", {11'd0, dout_vld}, 12'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // table vectors, back-to-back strobes
    for (int i = 0; i < 18; i++)
      drive_sample(vecs[i].addr, vecs[i].ws, vecs[i].amp, 1'b1, vecs[i].exp, 0);
    drain("table_drain");

    // latency: vld must appear only at the negedge after the 6th posedge from s_clk rise
    p0    = n_pulses;
    s_clk = 1'b1;
    @(negedge clk);
    s_clk = 1'b0;
    check("lat_1", {11'd0, dout_vld}, 12'd0);
    @(negedge clk);
    addr     = 12'd1024;
    wave_sel = WAVE_SINE;
    amp      = 9'd256;
    en       = 1'b1;
    exp_q.push_back(12'd2047);
    check("lat_2", {11'd0, dout_vld}, 12'd0);
    for (int k = 3; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("lat_%0d", k), {11'd0, dout_vld}, (k == 6) ? 12'd1 : 12'd0);
    end
    repeat (4) @(negedge clk);
    check("lat_one_pulse", 12'(n_pulses - p0), 12'd1);

    // enable low: no pulse, dout holds
    p0 = n_pulses;
    drive_sample(12'd3072, WAVE_SINE, 9'd256, 1'b0, 0, 10);
    check("en0_no_pulse", 12'(n_pulses - p0), 12'd0);
    check("en0_dout_hold", dout, 12'd2047);

    // reset asserted across E2 of an in-flight sample
    p0    = n_pulses;
    s_clk = 1'b1;
    @(negedge clk);
    s_clk = 1'b0;
    @(negedge clk);
    addr     = 12'd3072;
    wave_sel = WAVE_SAW;
    amp      = 9'd256;
    en       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_dout", dout, 12'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("rstmid_no_pulse", 12'(n_pulses - p0), 12'd0);
    check("rstmid_dout_hold", dout, 12'd0);
    drive_sample(12'd3072, WAVE_TRI, 9'd256, 1'b1, -2047, 0);
    drain("rstmid_recover");

    // random samples against the model
    for (int i = 0; i < 150; i++) begin
      int a;
      int ws;
      int am;
      logic e;
      a  = $urandom_range(0, 4095);
      ws = $urandom_range(0, 3);
      am = $urandom_range(0, 511);
      e  = ($urandom_range(0, 7) != 0);
      drive_sample(12'(a), 2'(ws), 9'(am), e, model(a, ws, am), $urandom_range(0, 3));
    end
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
